full_adder_reg: RTL and testbench

- Registered full adder: computes a + b + cin and presents sum/carry one clock after the operands are captured.
- Default WIDTH=1 gives exactly the classic 1-bit full adder truth table, with a registered output stage.
- WIDTH>1 chains WIDTH 1-bit cells as a ripple-carry adder.
- Used as the basic arithmetic leaf in the adders library and as a timing-clean drop-in where a combinational full adder would break a register-to-register path.

---
 rtl/adders_pkg.sv | 12 +
 rtl/full_adder_reg_if.sv | 26 ++
 rtl/full_adder_cell.sv | 16 +
 rtl/full_adder_reg.sv | 74 +++++++
 tb/tb_full_adder_reg.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/adders_pkg.sv
// Shared definitions for the adders library.
//   MAX_ADDER_WIDTH : widest operand any adder in the library accepts
//   fa_bit(a, b, c) : 1-bit full adder reference, returns {carry, sum}
package adders_pkg;

   localparam int MAX_ADDER_WIDTH = 64;

   function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
      return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
   endfunction

endpackage

// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for full_adder_reg.
//   in_valid, a, b, cin         : operands, driven by the master
//   out_valid, sum, cout, ovf   : registered result, driven by the slave (the adder)
// WIDTH must match the WIDTH of the full_adder_reg it is connected to.
interface full_adder_reg_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin,
      input  out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin,
      output out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : carry out
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high; clears out_valid, sum, cout, ovf
//   bus : full_adder_reg_if.slave
//         in_valid/a/b/cin in, out_valid/sum/cout/ovf out
// When in_valid is low the result registers hold and only out_valid drops.
module full_adder_reg
   import adders_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic           clk,
   input  logic           rst,
   full_adder_reg_if.slave bus
);

   if (WIDTH < 1 || WIDTH > MAX_ADDER_WIDTH) begin : g_bad_width
      $error("full_adder_reg: WIDTH out of range");
   end

   // c[i] is the carry into bit i; c[0] is cin, c[WIDTH] is the carry out.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a    (bus.a[i]),
         .b    (bus.b[i]),
         .cin  (c[i]),
         .sum  (s[i]),
         .cout (c[i+1])
      );
   end

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d,       sum_q;
   logic             cout_d,      cout_q;
   logic             ovf_d,       ovf_q;

   always_comb begin
      out_valid_d = bus.in_valid;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (bus.in_valid) begin
         sum_d  = s;
         cout_d = c[WIDTH];
         // signed overflow: carry into the MSB differs from carry out of it
         ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH 1, 4 and 8.
// Stimulus is applied on the falling edge and the expected result for the
// following rising edge is queued; one monitor per instance pops and compares
// shortly after each rising edge.
module tb_full_adder_reg;
   import adders_pkg::*;

   typedef struct packed {
      logic        v;
      logic        chk;
      logic        ovf;
      logic        cout;
      logic [63:0] sum;
   } exp_t;

   logic clk = 1'b0;
   logic rst1, rst4, rst8;
   int   checks   = 0;
   int   failures = 0;

   exp_t q1[$];
   exp_t q4[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   full_adder_reg_if #(.WIDTH(1)) if1 ();
   full_adder_reg_if #(.WIDTH(4)) if4 ();
   full_adder_reg_if #(.WIDTH(8)) if8 ();

   full_adder_reg #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));
   full_adder_reg #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
   full_adder_reg #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8));

   function automatic exp_t mk(input logic v, input logic chk, input logic ovf,
                               input logic cout, input logic [63:0] sum);
      exp_t e;
      e.v = v; e.chk = chk; e.ovf = ovf; e.cout = cout; e.sum = sum;
      return e;
   endfunction

   task automatic check_out(input string name, input exp_t e, input logic v,
                            input logic ovf, input logic cout, input logic [63:0] sum);
      checks++;
      if (v !== e.v) begin
         failures++;
         $display("FAIL %s out_valid: got %0b expected %0b (t=%0t)", name, v, e.v, $time);
      end
      if (e.chk) begin
         checks++;
         if ({ovf, cout, sum} !== {e.ovf, e.cout, e.sum}) begin
            failures++;
            $display("FAIL %s result: got sum=%0h cout=%0b ovf=%0b expected sum=%0h cout=%0b ovf=%0b (t=%0t)",
                     name, sum, cout, ovf, e.sum, e.cout, e.ovf, $time);
         end
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      if (q1.size() > 0)
         check_out("w1", q1.pop_front(), if1.out_valid, if1.ovf, if1.cout, 64'(if1.sum));
   end

   initial forever begin
      @(posedge clk); #1;
      if (q4.size() > 0)
         check_out("w4", q4.pop_front(), if4.out_valid, if4.ovf, if4.cout, 64'(if4.sum));
   end

   initial forever begin
      @(posedge clk); #1;
      if (q8.size() > 0)
         check_out("w8", q8.pop_front(), if8.out_valid, if8.ovf, if8.cout, 64'(if8.sum));
   end

   task automatic drv1(input logic r, input logic v, input logic a, input logic b,
                       input logic c, input exp_t e);
      @(negedge clk);
      rst1 = r; if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = c;
      q1.push_back(e);
   endtask

   task automatic drv4(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic c, input exp_t e);
      @(negedge clk);
      rst4 = r; if4.in_valid = v; if4.a = a; if4.b = b; if4.cin = c;
      q4.push_back(e);
   endtask

   task automatic drv8(input logic r, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input exp_t e);
      @(negedge clk);
      rst8 = r; if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = c;
      q8.push_back(e);
   endtask

   // Reference for 8-bit: plain integer sum, MSB carry/ovf through fa_bit.
   function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] full;
      logic [7:0] low;
      logic [1:0] msb;
      full = {1'b0, a} + {1'b0, b} + 9'(c);
      low  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + 8'(c);
      msb  = fa_bit(a[7], b[7], low[7]);
      return mk(1'b1, 1'b1, msb[1] ^ low[7], msb[1], 64'(full[7:0]));
   endfunction

   initial begin
      logic [1:0] tab1 [8];
      logic [2:0] abc;
      logic [7:0] ra, rb;
      logic       rc;
      exp_t       last8;

      tab1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      rst1 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
      if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;

      // WIDTH=1: reset, exhaustive truth table
      drv1(1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0));
      drv1(1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0));
      for (int i = 0; i < 8; i++) begin
         abc = 3'(i);
         drv1(0, 1, abc[2], abc[1], abc[0],
              mk(1, 1, tab1[i][1] ^ abc[0], tab1[i][1], 64'(tab1[i][0])));
      end
      // reset wins over a valid operand in the same cycle
      drv1(1, 1, 1, 1, 1, mk(0, 1, 0, 0, 0));
      drv1(0, 1, 1, 0, 0, mk(1, 1, 0, 0, 1));
      // hold on idle, unknown operands while idle
      drv1(0, 1, 1, 0, 1, mk(1, 1, 0, 1, 0));
      drv1(0, 0, 1'bx, 1'bx, 1'bx, mk(0, 1, 0, 1, 0));
      drv1(0, 0, 1'bx, 1'bx, 1'bx, mk(0, 1, 0, 1, 0));
      drv1(0, 0, 1'bx, 1'bx, 1'bx, mk(0, 1, 0, 1, 0));
      // reset, idle, then first valid op one cycle later
      drv1(1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0));
      drv1(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0));
      drv1(0, 1, 1, 1, 0, mk(1, 1, 1, 1, 0));
      drv1(0, 0, 0, 0, 0, mk(0, 1, 1, 1, 0));

      // WIDTH=4: ripple and signed overflow corners
      drv4(1, 0, 4'h0, 4'h0, 0, mk(0, 1, 0, 0, 0));
      drv4(0, 1, 4'hF, 4'h0, 1, mk(1, 1, 0, 1, 64'h0));
      drv4(0, 1, 4'h7, 4'h1, 0, mk(1, 1, 1, 0, 64'h8));
      drv4(0, 1, 4'h8, 4'h8, 0, mk(1, 1, 1, 1, 64'h0));
      drv4(0, 0, 4'h3, 4'h3, 1, mk(0, 1, 1, 1, 64'h0));
      drv4(0, 1, 4'h5, 4'h3, 1, mk(1, 1, 1, 0, 64'h9));
      drv4(0, 1, 4'h0, 4'h0, 0, mk(1, 1, 0, 0, 64'h0));
      drv4(0, 1, 4'hF, 4'hF, 1, mk(1, 1, 0, 1, 64'hF));
      drv4(0, 0, 4'h0, 4'h0, 0, mk(0, 1, 0, 1, 64'hF));

      // WIDTH=8: back-to-back random
      drv8(1, 0, 8'h00, 8'h00, 0, mk(0, 1, 0, 0, 0));
      last8 = mk(0, 1, 0, 0, 0);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         last8 = model8(ra, rb, rc);
         drv8(0, 1, ra, rb, rc, last8);
      end
      last8.v = 1'b0;
      drv8(0, 0, 8'h00, 8'h00, 0, last8);

      repeat (3) @(negedge clk);
      if (q1.size() + q4.size() + q8.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending results, expected 0",
                  q1.size() + q4.size() + q8.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
